// File: rtl/bp_me_cache_dma_mux.sv
// Multiplexes N bsg_cache DMA channels onto one DRAM command/response stream pair.
// Optional feature macro: BP_ME_DMA_MUX_UNSOLICITED_ERR_EN (adds sticky err_o for unsolicited read beats).
module bp_me_cache_dma_mux #(
  parameter int num_dma_p        = 2,
  parameter int paddr_width_p    = 40,
  parameter int dma_data_width_p = 64,
  parameter int block_width_p    = 512,
  parameter int rd_fifo_els_p    = 4
) (
  input  logic                                        clk_i,
  input  logic                                        reset_i,
  input  logic [num_dma_p*(1+paddr_width_p)-1:0]      dma_pkt_i,
  input  logic [num_dma_p-1:0]                        dma_pkt_v_i,
  output logic [num_dma_p-1:0]                        dma_pkt_yumi_o,
  output logic [dma_data_width_p-1:0]                 dma_data_o,
  output logic [num_dma_p-1:0]                        dma_data_v_o,
  input  logic [num_dma_p-1:0]                        dma_data_ready_i,
  input  logic [num_dma_p*dma_data_width_p-1:0]       dma_data_i,
  input  logic [num_dma_p-1:0]                        dma_data_v_i,
  output logic [num_dma_p-1:0]                        dma_data_yumi_o,
  output logic                                        mem_cmd_wr_o,
  output logic [paddr_width_p-1:0]                    mem_cmd_addr_o,
  output logic                                        mem_cmd_header_v_o,
  input  logic                                        mem_cmd_header_yumi_i,
  output logic [dma_data_width_p-1:0]                 mem_cmd_data_o,
  output logic                                        mem_cmd_data_v_o,
  input  logic                                        mem_cmd_data_yumi_i,
  input  logic                                        mem_resp_header_v_i,
  output logic                                        mem_resp_header_ready_o,
  input  logic [dma_data_width_p-1:0]                 mem_resp_data_i,
  input  logic                                        mem_resp_data_v_i,
  output logic                                        mem_resp_data_ready_o
`ifdef BP_ME_DMA_MUX_UNSOLICITED_ERR_EN
  ,
  output logic                                        err_o
`endif
);

  localparam int beats_lp     = block_width_p / dma_data_width_p;
  localparam int cnt_w_lp     = (beats_lp > 1) ? $clog2(beats_lp) : 1;
  localparam int id_w_lp      = (num_dma_p > 1) ? $clog2(num_dma_p) : 1;
  localparam int ptr_w_lp     = (rd_fifo_els_p > 1) ? $clog2(rd_fifo_els_p) : 1;
  localparam int fcnt_w_lp    = $clog2(rd_fifo_els_p + 1);

  typedef enum logic {e_idle, e_wr} state_e;

  state_e                  state_q, state_d;
  logic [id_w_lp-1:0]      rr_q, rr_d;
  logic [id_w_lp-1:0]      wr_ch_q, wr_ch_d;
  logic [cnt_w_lp-1:0]     wr_cnt_q, wr_cnt_d;
  logic [cnt_w_lp-1:0]     rd_cnt_q, rd_cnt_d;

  logic [id_w_lp-1:0]      fifo_mem [rd_fifo_els_p];
  logic [ptr_w_lp-1:0]     wptr_q, wptr_d;
  logic [ptr_w_lp-1:0]     rptr_q, rptr_d;
  logic [fcnt_w_lp-1:0]    fcnt_q, fcnt_d;

  logic [num_dma_p-1:0]        pkt_wr;
  logic [paddr_width_p-1:0]    pkt_addr [num_dma_p];
  logic [dma_data_width_p-1:0] wdata    [num_dma_p];

  genvar gi;
  generate
    for (gi = 0; gi < num_dma_p; gi++) begin : g_unpack
      assign pkt_wr[gi]   = dma_pkt_i[gi*(1+paddr_width_p)+paddr_width_p];
      assign pkt_addr[gi] = dma_pkt_i[gi*(1+paddr_width_p) +: paddr_width_p];
      assign wdata[gi]    = dma_data_i[gi*dma_data_width_p +: dma_data_width_p];
    end
  endgenerate

  logic                 fifo_empty, fifo_full;
  logic [id_w_lp-1:0]   head_id;
  logic [num_dma_p-1:0] eligible;
  logic                 grant_v;
  logic [id_w_lp-1:0]   grant_id;
  int                   arb_idx;
  logic                 hdr_fire, wr_beat, wr_last, rd_beat, rd_last, push, pop;

  assign fifo_empty = (fcnt_q == '0);
  assign fifo_full  = (fcnt_q == fcnt_w_lp'(rd_fifo_els_p));
  assign head_id    = fifo_mem[rptr_q];

  // Full is registered, so a same-cycle pop never unmasks reads; writes bypass the mask.
  assign eligible = dma_pkt_v_i & (pkt_wr | {num_dma_p{~fifo_full}});

  always_comb begin
    grant_v  = 1'b0;
    grant_id = '0;
    arb_idx  = 0;
    for (int i = 0; i < num_dma_p; i++) begin
      arb_idx = int'(rr_q) + i;
      if (arb_idx >= num_dma_p) arb_idx = arb_idx - num_dma_p;
      if (!grant_v && eligible[arb_idx]) begin
        grant_v  = 1'b1;
        grant_id = id_w_lp'(arb_idx);
      end
    end
  end

  assign mem_cmd_wr_o   = pkt_wr[grant_id];
  assign mem_cmd_addr_o = pkt_addr[grant_id];
  assign mem_cmd_data_o = wdata[wr_ch_q];

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= e_idle;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      e_idle:  if (hdr_fire && mem_cmd_wr_o) state_d = e_wr;
      e_wr:    if (wr_last) state_d = e_idle;
      default: state_d = e_idle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    mem_cmd_header_v_o = 1'b0;
    mem_cmd_data_v_o   = 1'b0;
    dma_pkt_yumi_o     = '0;
    dma_data_yumi_o    = '0;
    if (!reset_i) begin
      if (state_q == e_idle) begin
        mem_cmd_header_v_o = grant_v;
        if (grant_v && mem_cmd_header_yumi_i) dma_pkt_yumi_o[grant_id] = 1'b1;
      end else begin
        mem_cmd_data_v_o = dma_data_v_i[wr_ch_q];
        if (dma_data_v_i[wr_ch_q] && mem_cmd_data_yumi_i) dma_data_yumi_o[wr_ch_q] = 1'b1;
      end
    end
  end

  assign hdr_fire = mem_cmd_header_v_o && mem_cmd_header_yumi_i;
  assign wr_beat  = mem_cmd_data_v_o && mem_cmd_data_yumi_i;
  assign wr_last  = wr_beat && (wr_cnt_q == cnt_w_lp'(beats_lp - 1));

  always_comb begin
    rr_d     = rr_q;
    wr_ch_d  = wr_ch_q;
    wr_cnt_d = wr_cnt_q;
    if (hdr_fire) begin
      if (int'(grant_id) == num_dma_p - 1) rr_d = '0;
      else                                 rr_d = grant_id + 1'b1;
      if (mem_cmd_wr_o) wr_ch_d = grant_id;
    end
    if (wr_last)      wr_cnt_d = '0;
    else if (wr_beat) wr_cnt_d = wr_cnt_q + 1'b1;
  end

  // Read return path; only registered FIFO state feeds back into the command side.
  assign dma_data_o              = mem_resp_data_i;
  assign mem_resp_header_ready_o = 1'b1;

  always_comb begin
    dma_data_v_o = '0;
    if (!reset_i && mem_resp_data_v_i && !fifo_empty) dma_data_v_o[head_id] = 1'b1;
  end

`ifdef BP_ME_DMA_MUX_UNSOLICITED_ERR_EN
  logic err_q, err_d;
  assign mem_resp_data_ready_o = !reset_i && (fifo_empty || dma_data_ready_i[head_id]);
  assign err_d = err_q || (mem_resp_data_v_i && fifo_empty);
  assign err_o = err_q;
  always_ff @(posedge clk_i) begin
    if (reset_i) err_q <= 1'b0;
    else         err_q <= err_d;
  end
`else
  assign mem_resp_data_ready_o = !reset_i && !fifo_empty && dma_data_ready_i[head_id];
`endif

  assign rd_beat = mem_resp_data_v_i && mem_resp_data_ready_o && !fifo_empty;
  assign rd_last = rd_beat && (rd_cnt_q == cnt_w_lp'(beats_lp - 1));
  assign push    = hdr_fire && !mem_cmd_wr_o;
  assign pop     = rd_last;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    fcnt_d   = fcnt_q;
    if (rd_last)      rd_cnt_d = '0;
    else if (rd_beat) rd_cnt_d = rd_cnt_q + 1'b1;
    if (push) wptr_d = (int'(wptr_q) == rd_fifo_els_p - 1) ? '0 : wptr_q + 1'b1;
    if (pop)  rptr_d = (int'(rptr_q) == rd_fifo_els_p - 1) ? '0 : rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wptr_q] <= grant_id;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_q     <= '0;
      wr_ch_q  <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      fcnt_q   <= '0;
    end else begin
      rr_q     <= rr_d;
      wr_ch_q  <= wr_ch_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      fcnt_q   <= fcnt_d;
    end
  end

  logic unused_resp_hdr;
  assign unused_resp_hdr = mem_resp_header_v_i;

endmodule

// File: tb/tb_bp_me_cache_dma_mux.sv
// Directed testbench for bp_me_cache_dma_mux (2 channels, 8 beats per block, 4-deep read tag FIFO).
module tb_bp_me_cache_dma_mux;
  localparam int N = 2, PW = 40, DW = 64, BEATS = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_i;
  logic [N-1:0][PW:0]   pkt_a;
  logic [N-1:0]         dma_pkt_v_i, dma_pkt_yumi_o;
  logic [DW-1:0]        dma_data_o;
  logic [N-1:0]         dma_data_v_o, dma_data_ready_i;
  logic [N-1:0][DW-1:0] wdata_a;
  logic [N-1:0]         dma_data_v_i, dma_data_yumi_o;
  logic                 mem_cmd_wr_o;
  logic [PW-1:0]        mem_cmd_addr_o;
  logic                 mem_cmd_header_v_o, mem_cmd_header_yumi_i;
  logic [DW-1:0]        mem_cmd_data_o;
  logic                 mem_cmd_data_v_o, mem_cmd_data_yumi_i;
  logic                 mem_resp_header_v_i, mem_resp_header_ready_o;
  logic [DW-1:0]        mem_resp_data_i;
  logic                 mem_resp_data_v_i, mem_resp_data_ready_o;
`ifdef BP_ME_DMA_MUX_UNSOLICITED_ERR_EN
  logic                 err_o;
`endif

  bp_me_cache_dma_mux dut (
    .clk_i(clk), .reset_i(reset_i),
    .dma_pkt_i(pkt_a), .dma_pkt_v_i(dma_pkt_v_i), .dma_pkt_yumi_o(dma_pkt_yumi_o),
    .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o), .dma_data_ready_i(dma_data_ready_i),
    .dma_data_i(wdata_a), .dma_data_v_i(dma_data_v_i), .dma_data_yumi_o(dma_data_yumi_o),
    .mem_cmd_wr_o(mem_cmd_wr_o), .mem_cmd_addr_o(mem_cmd_addr_o),
    .mem_cmd_header_v_o(mem_cmd_header_v_o), .mem_cmd_header_yumi_i(mem_cmd_header_yumi_i),
    .mem_cmd_data_o(mem_cmd_data_o), .mem_cmd_data_v_o(mem_cmd_data_v_o),
    .mem_cmd_data_yumi_i(mem_cmd_data_yumi_i),
    .mem_resp_header_v_i(mem_resp_header_v_i), .mem_resp_header_ready_o(mem_resp_header_ready_o),
    .mem_resp_data_i(mem_resp_data_i), .mem_resp_data_v_i(mem_resp_data_v_i),
    .mem_resp_data_ready_o(mem_resp_data_ready_o)
`ifdef BP_ME_DMA_MUX_UNSOLICITED_ERR_EN
    , .err_o(err_o)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1;
    pkt_a = '0; dma_pkt_v_i = '0; dma_data_ready_i = '0; wdata_a = '0; dma_data_v_i = '0;
    mem_cmd_header_yumi_i = 1'b0; mem_cmd_data_yumi_i = 1'b0; mem_resp_header_v_i = 1'b0;
    mem_resp_data_i = '0; mem_resp_data_v_i = 1'b0;
    tick(); tick();
    reset_i = 1'b0;
    settle();
    chk("rst_hdr_v", mem_cmd_header_v_o, 0);
    chk("rst_pkt_yumi", dma_pkt_yumi_o, 0);
    chk("rst_cmd_data_v", mem_cmd_data_v_o, 0);
    chk("rst_dma_data_v", dma_data_v_o, 0);
    chk("rst_resp_ready", mem_resp_data_ready_o, 0);
    chk("rst_resp_hdr_ready", mem_resp_header_ready_o, 1);

    // Test 1: simultaneous ch0 write and ch1 read, rr_ptr=0
    tick();
    pkt_a[0] = {1'b1, 40'h1000}; pkt_a[1] = {1'b0, 40'h2000}; dma_pkt_v_i = 2'b11;
    settle();
    chk("t1_hdr_v", mem_cmd_header_v_o, 1);
    chk("t1_hdr_wr", mem_cmd_wr_o, 1);
    chk("t1_hdr_addr", mem_cmd_addr_o, 64'h1000);
    chk("t1_yumi_before", dma_pkt_yumi_o, 0);
    mem_cmd_header_yumi_i = 1'b1;
    settle();
    chk("t1_pkt_yumi_ch0", dma_pkt_yumi_o, 2'b01);
    tick();
    dma_pkt_v_i = 2'b10; mem_cmd_header_yumi_i = 1'b0;
    dma_data_v_i = 2'b01; mem_cmd_data_yumi_i = 1'b1;
    for (int b = 0; b < BEATS; b++) begin
      wdata_a[0] = 64'hC000 + 64'(b);
      settle();
      chk("t1_wr_no_hdr", mem_cmd_header_v_o, 0);
      chk("t1_wr_v", mem_cmd_data_v_o, 1);
      chk("t1_wr_data", mem_cmd_data_o, 64'hC000 + 64'(b));
      chk("t1_wr_yumi", dma_data_yumi_o, 2'b01);
      tick();
    end
    dma_data_v_i = 2'b00; mem_cmd_data_yumi_i = 1'b0;
    settle();
    chk("t1_wr_done_v", mem_cmd_data_v_o, 0);
    chk("t1_rd_hdr_v", mem_cmd_header_v_o, 1);
    chk("t1_rd_hdr_wr", mem_cmd_wr_o, 0);
    chk("t1_rd_hdr_addr", mem_cmd_addr_o, 64'h2000);
    mem_cmd_header_yumi_i = 1'b1;
    settle();
    chk("t1_pkt_yumi_ch1", dma_pkt_yumi_o, 2'b10);
    tick();
    dma_pkt_v_i = 2'b00; mem_cmd_header_yumi_i = 1'b0;
    mem_resp_data_v_i = 1'b1; dma_data_ready_i = 2'b11;
    for (int b = 0; b < BEATS; b++) begin
      mem_resp_data_i = 64'hD000 + 64'(b);
      settle();
      chk("t1_rd_v_ch1", dma_data_v_o, 2'b10);
      chk("t1_rd_ready", mem_resp_data_ready_o, 1);
      chk("t1_rd_data", dma_data_o, 64'hD000 + 64'(b));
      tick();
    end
    mem_resp_data_v_i = 1'b0;
    settle();
    chk("t1_rd_done_v", dma_data_v_o, 0);
    chk("t1_rd_done_ready", mem_resp_data_ready_o, 0);

    // Test 2: FIFO fills after 4 reads; 5th header held until first block returns
    pkt_a[0] = {1'b0, 40'h3000}; pkt_a[1] = {1'b0, 40'h4000}; dma_pkt_v_i = 2'b11;
    mem_cmd_header_yumi_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("t2_grant", dma_pkt_yumi_o, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
    end
    settle();
    chk("t2_full_hdr_v", mem_cmd_header_v_o, 0);
    chk("t2_full_yumi", dma_pkt_yumi_o, 0);
    mem_resp_data_v_i = 1'b1;
    for (int b = 0; b < BEATS; b++) begin
      mem_resp_data_i = 64'hB0 + 64'(b);
      settle();
      chk("t2_full_hold", mem_cmd_header_v_o, 0);
      chk("t2_ret_v_ch0", dma_data_v_o, 2'b01);
      chk("t2_ret_data", dma_data_o, 64'hB0 + 64'(b));
      tick();
    end
    mem_resp_data_v_i = 1'b0;
    settle();
    chk("t2_5th_hdr_v", mem_cmd_header_v_o, 1);
    chk("t2_5th_addr", mem_cmd_addr_o, 64'h3000);
    chk("t2_5th_yumi", dma_pkt_yumi_o, 2'b01);
    tick();
    dma_pkt_v_i = 2'b00; mem_cmd_header_yumi_i = 1'b0;

    // Test 3: in-order return, ch1 block then ch0 block
    mem_resp_data_v_i = 1'b1;
    for (int b = 0; b < BEATS; b++) begin
      mem_resp_data_i = 64'hA0 + 64'(b);
      settle();
      chk("t3_v_ch1", dma_data_v_o, 2'b10);
      chk("t3_data", dma_data_o, 64'hA0 + 64'(b));
      tick();
    end

    // Test 4: ch0 not ready for 3 cycles mid-block
    for (int b = 0; b < BEATS; b++) begin
      if (b == 3) begin
        dma_data_ready_i = 2'b10;
        for (int s = 0; s < 3; s++) begin
          mem_resp_data_i = 64'hB8 + 64'(b);
          settle();
          chk("t4_stall_ready", mem_resp_data_ready_o, 0);
          chk("t4_stall_v", dma_data_v_o, 2'b01);
          tick();
        end
        dma_data_ready_i = 2'b11;
      end
      mem_resp_data_i = 64'hB8 + 64'(b);
      settle();
      chk("t4_v_ch0", dma_data_v_o, 2'b01);
      chk("t4_ready", mem_resp_data_ready_o, 1);
      tick();
    end
    for (int h = 0; h < 2; h++) begin
      for (int b = 0; b < BEATS; b++) begin
        settle();
        chk("t4_drain_head", dma_data_v_o, (h == 0) ? 2'b10 : 2'b01);
        tick();
      end
    end
    mem_resp_data_v_i = 1'b0;
    settle();
    chk("t4_empty_ready", mem_resp_data_ready_o, 0);

    // Test 5: reset during write beat 4 with a read outstanding
    pkt_a[1] = {1'b0, 40'h5000}; dma_pkt_v_i = 2'b10; mem_cmd_header_yumi_i = 1'b1;
    settle();
    chk("t5_rd_yumi", dma_pkt_yumi_o, 2'b10);
    tick();
    pkt_a[0] = {1'b1, 40'h6000}; dma_pkt_v_i = 2'b01;
    settle();
    chk("t5_wr_hdr", mem_cmd_wr_o, 1);
    chk("t5_wr_yumi", dma_pkt_yumi_o, 2'b01);
    tick();
    dma_pkt_v_i = 2'b00; mem_cmd_header_yumi_i = 1'b0;
    dma_data_v_i = 2'b01; mem_cmd_data_yumi_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      wdata_a[0] = 64'hE0 + 64'(b);
      settle();
      chk("t5_wr_data", mem_cmd_data_o, 64'hE0 + 64'(b));
      tick();
    end
    reset_i = 1'b1;
    settle();
    chk("t5_rst_cmd_v", mem_cmd_data_v_o, 0);
    chk("t5_rst_dyumi", dma_data_yumi_o, 0);
    tick();
    reset_i = 1'b0;
    pkt_a[0] = {1'b0, 40'h7000}; pkt_a[1] = {1'b0, 40'h8000}; dma_pkt_v_i = 2'b11;
    mem_resp_data_v_i = 1'b1;
    settle();
    chk("t5_post_cmd_v", mem_cmd_data_v_o, 0);
    chk("t5_post_dma_v", dma_data_v_o, 0);
    chk("t5_post_hdr_v", mem_cmd_header_v_o, 1);
    chk("t5_post_addr_rr0", mem_cmd_addr_o, 64'h7000);
`ifdef BP_ME_DMA_MUX_UNSOLICITED_ERR_EN
    chk("t5_post_ready", mem_resp_data_ready_o, 1);
    chk("t6_err_init", err_o, 0);
`else
    chk("t5_post_ready", mem_resp_data_ready_o, 0);
`endif

    // Test 6: unsolicited response beat with empty FIFO
    dma_pkt_v_i = 2'b00; dma_data_v_i = 2'b00; mem_cmd_data_yumi_i = 1'b0;
    tick();
    mem_resp_data_v_i = 1'b0;
    settle();
`ifdef BP_ME_DMA_MUX_UNSOLICITED_ERR_EN
    chk("t6_err_set", err_o, 1);
    tick();
    chk("t6_err_sticky", err_o, 1);
`else
    mem_resp_data_v_i = 1'b1;
    settle();
    chk("t6_unsol_ready", mem_resp_data_ready_o, 0);
    chk("t6_unsol_v", dma_data_v_o, 0);
    tick();
    chk("t6_unsol_ready2", mem_resp_data_ready_o, 0);
    mem_resp_data_v_i = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
